// File: rtl/waterfall_capture.sv
// Captures a coefficient row on a decimated trigger and streams it bin by bin over valid/ready.
// Optional peak search is built when WATERFALL_PEAK_TRACK_EN is defined; otherwise peak outputs read 0.
module waterfall_capture #(
  parameter int N_BINS = 128,
  parameter int COEF_W = 16,
  parameter int DECIM  = 1
) (
  input  logic                        CLK_waterfall,
  input  logic                        RST,
  input  logic                        enable,
  input  logic [N_BINS*COEF_W-1:0]    coef_flat,
  input  logic                        out_ready,
  input  logic                        overrun_clr,
  output logic                        out_valid,
  output logic [COEF_W-1:0]           out_data,
  output logic [$clog2(N_BINS)-1:0]   out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun,
  output logic [15:0]                 frame_count,
  output logic [$clog2(N_BINS)-1:0]   peak_index,
  output logic [COEF_W-1:0]           peak_value
);

  localparam int IDX_W = $clog2(N_BINS);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                decim_cnt_q, decim_cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [N_BINS*COEF_W-1:0]   shadow_q, shadow_d;
  logic                       out_valid_q, out_valid_d;
  logic [COEF_W-1:0]          out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic                       overrun_q, overrun_d;
  logic [15:0]                frame_count_q, frame_count_d;

  logic                       trigger;
  logic                       xfer;
  logic [IDX_W-1:0]           idx_nxt;

  assign trigger = enable && (decim_cnt_q == 16'(DECIM - 1));
  assign xfer    = out_valid_q && out_ready;
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    decim_cnt_d   = decim_cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;

    if (enable) begin
      decim_cnt_d = trigger ? 16'd0 : decim_cnt_q + 16'd1;
    end

    // A trigger that lands while a row is still streaming, including its final beat, is lost.
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (state_q == STREAM && trigger) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          shadow_d    = coef_flat;
          idx_d       = '0;
          state_d     = STREAM;
          out_valid_d = 1'b1;
          out_data_d  = coef_flat[COEF_W-1:0];
          out_last_d  = 1'b0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (&idx_q) begin
            state_d       = IDLE;
            out_valid_d   = 1'b0;
            out_last_d    = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = shadow_q[idx_nxt*COEF_W +: COEF_W];
            out_last_d = &idx_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_waterfall or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      decim_cnt_q   <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      decim_cnt_q   <= decim_cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = idx_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q == STREAM);
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

`ifdef WATERFALL_PEAK_TRACK_EN
  logic [COEF_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]  run_idx_q, run_idx_d;
  logic [COEF_W-1:0] peak_value_q, peak_value_d;
  logic [IDX_W-1:0]  peak_index_q, peak_index_d;
  logic              take;

  // Strict greater-than keeps the lowest index on ties; bin 0 always seeds the maximum.
  always_comb begin
    take         = (idx_q == '0) || ($signed(out_data_q) > $signed(run_max_q));
    run_max_d    = run_max_q;
    run_idx_d    = run_idx_q;
    peak_value_d = peak_value_q;
    peak_index_d = peak_index_q;
    if (xfer) begin
      if (take) begin
        run_max_d = out_data_q;
        run_idx_d = idx_q;
      end
      if (&idx_q) begin
        peak_value_d = take ? out_data_q : run_max_q;
        peak_index_d = take ? idx_q : run_idx_q;
      end
    end
  end

  always_ff @(posedge CLK_waterfall or posedge RST) begin
    if (RST) begin
      run_max_q    <= '0;
      run_idx_q    <= '0;
      peak_value_q <= '0;
      peak_index_q <= '0;
    end else begin
      run_max_q    <= run_max_d;
      run_idx_q    <= run_idx_d;
      peak_value_q <= peak_value_d;
      peak_index_q <= peak_index_d;
    end
  end

  assign peak_value = peak_value_q;
  assign peak_index = peak_index_q;
`else
  assign peak_value = '0;
  assign peak_index = '0;
`endif

endmodule

// File: tb/tb_waterfall_capture.sv
// Directed bench for waterfall_capture: 8-bin row table, overrun/reset corners, DECIM=4 and 128-bin stall cases.
module tb_waterfall_capture;

`ifdef WATERFALL_PEAK_TRACK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  // 8 bins, DECIM=1
  logic         en8 = 0, rdy8 = 0, clr8 = 0;
  logic [127:0] coef8 = '0;
  logic         vld8, last8, busy8, ovr8;
  logic [15:0]  dat8, fc8, pval8;
  logic [2:0]   idx8, pidx8;

  // 4 bins, DECIM=4
  logic         en4 = 0, rdy4 = 0, clr4 = 0;
  logic [63:0]  coef4 = '0;
  logic         vld4, last4, busy4, ovr4;
  logic [15:0]  dat4, fc4, pval4;
  logic [1:0]   idx4, pidx4;

  // 128 bins, DECIM=1
  logic          en128 = 0, rdy128 = 0, clr128 = 0;
  logic [2047:0] coef128 = '0;
  logic          vld128, last128, busy128, ovr128;
  logic [15:0]   dat128, fc128, pval128;
  logic [6:0]    idx128, pidx128;

  waterfall_capture #(.N_BINS(8), .COEF_W(16), .DECIM(1)) dut (
    .CLK_waterfall(clk), .RST(rst), .enable(en8), .coef_flat(coef8), .out_ready(rdy8),
    .overrun_clr(clr8), .out_valid(vld8), .out_data(dat8), .out_index(idx8), .out_last(last8),
    .busy(busy8), .overrun(ovr8), .frame_count(fc8), .peak_index(pidx8), .peak_value(pval8));

  waterfall_capture #(.N_BINS(4), .COEF_W(16), .DECIM(4)) dut4 (
    .CLK_waterfall(clk), .RST(rst), .enable(en4), .coef_flat(coef4), .out_ready(rdy4),
    .overrun_clr(clr4), .out_valid(vld4), .out_data(dat4), .out_index(idx4), .out_last(last4),
    .busy(busy4), .overrun(ovr4), .frame_count(fc4), .peak_index(pidx4), .peak_value(pval4));

  waterfall_capture #(.N_BINS(128), .COEF_W(16), .DECIM(1)) dut128 (
    .CLK_waterfall(clk), .RST(rst), .enable(en128), .coef_flat(coef128), .out_ready(rdy128),
    .overrun_clr(clr128), .out_valid(vld128), .out_data(dat128), .out_index(idx128), .out_last(last128),
    .busy(busy128), .overrun(ovr128), .frame_count(fc128), .peak_index(pidx128), .peak_value(pval128));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        exp_vld;
    logic [15:0] exp_dat;
    logic [2:0]  exp_idx;
    logic        exp_last;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t        vecs[26];
  logic [15:0] bins_a[8];
  logic [15:0] row128[128];

  initial begin
    bins_a = '{16'd3, 16'hFFF9, 16'd12, 16'd12, 16'd0, 16'hFFFF, 16'd5, 16'd9};
    for (int k = 0; k < 8; k++) coef8[k*16 +: 16] = bins_a[k];

    // Rows 0..8: one row at full rate. Rows 9..25: same row with ready alternating 0,1.
    for (int r = 0; r < 9; r++) begin
      vecs[r].en = (r == 0); vecs[r].rdy = 1'b1; vecs[r].exp_vld = (r < 8);
      vecs[r].exp_idx = 3'(r); vecs[r].exp_dat = bins_a[r % 8];
      vecs[r].exp_last = (r == 7); vecs[r].exp_fc = (r == 8) ? 16'd1 : 16'd0;
    end
    vecs[9].en = 1'b1; vecs[9].rdy = 1'b0; vecs[9].exp_vld = 1'b1; vecs[9].exp_idx = 3'd0;
    vecs[9].exp_dat = bins_a[0]; vecs[9].exp_last = 1'b0; vecs[9].exp_fc = 16'd1;
    for (int j = 0; j < 16; j++) begin
      vecs[10+j].en = 1'b0; vecs[10+j].rdy = 1'(j % 2);
      vecs[10+j].exp_vld = (j < 15);
      vecs[10+j].exp_idx = 3'((j + 1) / 2);
      vecs[10+j].exp_dat = bins_a[((j + 1) / 2) % 8];
      vecs[10+j].exp_last = ((j + 1) / 2 == 7);
      vecs[10+j].exp_fc = (j == 15) ? 16'd2 : 16'd1;
    end

    // Reset state, checked while reset is still asserted.
    #1 rst = 1'b1;
    #3;
    chk("rst_vld", 32'(vld8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_ovr", 32'(ovr8), 0);
    chk("rst_fc", 32'(fc8), 0);
    chk("rst_dat", 32'(dat8), 0);
    chk("rst_idx", 32'(idx8), 0);
    chk("rst_last", 32'(last8), 0);
    chk("rst_pidx", 32'(pidx8), 0);
    chk("rst_pval", 32'(pval8), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int r = 0; r < 26; r++) begin
      en8 = vecs[r].en; rdy8 = vecs[r].rdy;
      tick();
      chk($sformatf("tbl%0d_vld", r), 32'(vld8), 32'(vecs[r].exp_vld));
      chk($sformatf("tbl%0d_busy", r), 32'(busy8), 32'(vecs[r].exp_vld));
      chk($sformatf("tbl%0d_fc", r), 32'(fc8), 32'(vecs[r].exp_fc));
      if (vecs[r].exp_vld) begin
        chk($sformatf("tbl%0d_dat", r), 32'(dat8), 32'(vecs[r].exp_dat));
        chk($sformatf("tbl%0d_idx", r), 32'(idx8), 32'(vecs[r].exp_idx));
        chk($sformatf("tbl%0d_last", r), 32'(last8), 32'(vecs[r].exp_last));
      end
    end
    chk("row_pidx", 32'(pidx8), PEAK_ON ? 32'd2 : 32'd0);
    chk("row_pval", 32'(pval8), PEAK_ON ? 32'd12 : 32'd0);
    chk("row_ovr", 32'(ovr8), 0);

    // Trigger coincident with the final transfer is dropped and flags overrun.
    en8 = 1; rdy8 = 1; tick();
    en8 = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("lastbeat_idx", 32'(idx8), 7);
    chk("lastbeat_last", 32'(last8), 1);
    en8 = 1; tick(); en8 = 0;
    chk("coinc_vld", 32'(vld8), 0);
    chk("coinc_busy", 32'(busy8), 0);
    chk("coinc_ovr", 32'(ovr8), 1);
    chk("coinc_fc", 32'(fc8), 3);
    tick();
    chk("coinc_norow", 32'(vld8), 0);
    clr8 = 1; tick(); clr8 = 0;
    chk("clr_ovr", 32'(ovr8), 0);

    // Clear and overrun in the same cycle: overrun stays set.
    en8 = 1; tick();
    clr8 = 1; tick();
    en8 = 0; clr8 = 0;
    chk("setwins_ovr", 32'(ovr8), 1);
    clr8 = 1; tick(); clr8 = 0;
    chk("clr2_ovr", 32'(ovr8), 0);
    begin
      int guard = 0;
      while (vld8 && guard < 12) begin tick(); guard++; end
      chk("drain_timeout", 32'(vld8), 0);
    end
    chk("drain_fc", 32'(fc8), 4);

    // Reset mid-row aborts it; next trigger restarts at index 0.
    en8 = 1; tick(); en8 = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_idx", 32'(idx8), 4);
    #1 rst = 1'b1;
    #1;
    chk("midrst_vld", 32'(vld8), 0);
    chk("midrst_fc", 32'(fc8), 0);
    chk("midrst_busy", 32'(busy8), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("postrst_novld", 32'(vld8), 0);

    // All bins at the most negative value.
    coef8 = {8{16'h8000}};
    en8 = 1; tick(); en8 = 0;
    chk("neg_vld", 32'(vld8), 1);
    chk("neg_idx", 32'(idx8), 0);
    chk("neg_dat", 32'(dat8), 32'h8000);
    for (int i = 0; i < 8; i++) tick();
    chk("neg_done", 32'(vld8), 0);
    chk("neg_fc", 32'(fc8), 1);
    chk("neg_pidx", 32'(pidx8), 0);
    chk("neg_pval", 32'(pval8), PEAK_ON ? 32'h8000 : 32'd0);

    // DECIM=4: four bursts of four enabled cycles (one gap to show the counter holding), fast sink.
    coef4 = {16'd40, 16'd30, 16'd20, 16'd10};
    rdy4 = 1;
    for (int b = 0; b < 4; b++) begin
      en4 = 1;
      for (int c = 0; c < 4; c++) begin
        if (c == 2) begin
          en4 = 0; tick();
          chk($sformatf("d4_b%0d_hold", b), 32'(vld4), 0);
          en4 = 1;
        end
        tick();
        chk($sformatf("d4_b%0d_c%0d_vld", b, c), 32'(vld4), (c == 3) ? 32'd1 : 32'd0);
      end
      en4 = 0;
      chk($sformatf("d4_b%0d_idx", b), 32'(idx4), 0);
      for (int i = 0; i < 4; i++) tick();
      chk($sformatf("d4_b%0d_end", b), 32'(vld4), 0);
    end
    chk("d4_fc", 32'(fc4), 4);
    chk("d4_ovr", 32'(ovr4), 0);

    // 128 bins, sink stalled 200 cycles while coefficients keep changing.
    for (int k = 0; k < 128; k++) begin
      row128[k] = 16'(k * 5 - 300);
      coef128[k*16 +: 16] = row128[k];
    end
    en128 = 1; rdy128 = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      for (int k = 0; k < 128; k++) coef128[k*16 +: 16] = 16'(7000 + cyc + k);
    end
    chk("b128_ovr", 32'(ovr128), 1);
    chk("b128_vld", 32'(vld128), 1);
    chk("b128_idx0", 32'(idx128), 0);
    en128 = 0; rdy128 = 1;
    for (int k = 0; k < 128; k++) begin
      chk($sformatf("b128_dat%0d", k), 32'(dat128), 32'(row128[k]));
      chk($sformatf("b128_idx%0d", k), 32'(idx128), 32'(k));
      tick();
    end
    chk("b128_end", 32'(vld128), 0);
    chk("b128_fc", 32'(fc128), 1);
    clr128 = 1; tick(); clr128 = 0;
    chk("b128_clr", 32'(ovr128), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
